cordic_vectoring_iter: RTL and testbench
========================================

# cordic_vectoring_iter

Iterative vectoring-mode CORDIC: the inverse of the rotation pipeline stages. Instead of driving the residual angle z to zero, it drives y to zero and accumulates the angle, producing magnitude sqrt(x²+y²) (optionally gain-corrected) and atan2(y,x) for one (x,y) pair per transaction. It reuses one micro-rotation datapath over ITER cycles and sits beside the rotation pipeline as its Cartesian-to-polar counterpart, with valid/ready handshakes on both sides.

## Interface
- WIDTH, 32: signed input width of x_in/y_in.
- ITER, 16: micro-rotations, range 1..WIDTH-1.
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  synchronous reset, active-low.
- in_valid  in  1  input pair valid.
- in_ready  out  1  high only in IDLE.
- x_in, y_in  in  WIDTH  signed two's-complement operands.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  downstream accepts result.
- mag_out  out  WIDTH+2  unsigned magnitude.
- angle_out  out  32  signed angle, Q16.16 degrees, range (-180, +180].

## Operation
- States: IDLE, PRE, ITER, COMP (only with macro), DONE.
- IDLE: in_ready=1; on in_valid&&in_ready, sign-extend inputs to WIDTH+2 into x,y; z=0; go PRE.
- PRE (quadrant fold): x<0 & y>=0 -> x'=y, y'=-x, z=+90°; x<0 & y<0 -> x'=-y, y'=x, z=-90°; else unchanged, z=0. If x==0 & y==0, set zero flag. cnt=0; go ITER.
- ITER step i=cnt: if y>=0: x+=y>>>i, y-=x>>>i, z+=ATAN[i]; else x-=y>>>i, y+=x>>>i, z-=ATAN[i]. All updates use pre-step values. Shifts are arithmetic. After cnt==ITER-1, go COMP or DONE.
- Zero flag: force mag_out=0, angle_out=0 regardless of iterations.
- Internal x,y are WIDTH+2 bits (covers growth 1.647·√2); no saturation needed; z is 32 bits, no wrap for legal input.
- DONE: out_valid=1, mag_out=x, angle_out=z stable; on out_ready go IDLE.
- Reset values: out_valid=0, mag_out=0, angle_out=0, state=IDLE, so in_ready=1 the first cycle after reset deasserts.
- Reset mid-transaction (any state): next edge returns to IDLE; in-flight result discarded, no out_valid.
- in_valid while busy: ignored (in_ready=0); upstream must hold.
- Inputs (-2^(WIDTH-1), 0) must fold to angle 180°, never -180°.

## Timing
- Accept edge E0 -> PRE at E1 -> iterations at E2..E(ITER+1) -> out_valid high after E(ITER+1) (ITER+2 with macro).
- Latency from accept edge to out_valid: ITER+1 cycles (ITER+2 with CORDIC_VEC_GAIN_COMP_EN).
- DONE->IDLE on the out_ready edge; in_ready high the next cycle. Max throughput one result per ITER+3 cycles (no comp, out_ready tied high).
- No combinational path from in_valid to in_ready or from out_ready to out_valid.

## Configuration
- CORDIC_VEC_GAIN_COMP_EN defined: COMP state, one cycle, mag = (x · GAIN_INV) >>> 16, with GAIN_INV=0x9B75 (≈0.60725, Q0.16); mag_out ≈ true magnitude.
- Undefined: no COMP state, no multiplier; mag_out = K·|v|, K≈1.64676; latency one cycle shorter.

## Structure
- Package cordic_pkg: ATAN table, Q16.16 degrees, entries 0..31 (ATAN[0]=0x002D0000, ATAN[1]=0x001A90A7, ...), ANG_90=0x005A0000, GAIN_INV, state enum.
- Sub-module cordic_vec_step: combinational single micro-rotation (x,y,z,shift,atan -> x',y',z'). The FSM, counter, handshake and registers live in the top.

## Test plan
- x=30000, y=40000 -> angle_out ≈ 3481934 (53.130°) ±150 LSB; mag_out ≈ 82338 (no comp) / 50000±4 (comp); out_valid exactly ITER+1 / ITER+2 cycles after accept.
- Quadrant sweep (1000,0),(0,1000),(-1000,0),(0,-1000),(-1000,-1000) -> 0°, 90°, 180°, -90°, -135° (0x FF790000) ±150 LSB each.
- x=y=0 -> mag_out=0, angle_out=0 exactly.
- out_ready held low 10 cycles in DONE -> out_valid, mag_out, angle_out stable; in_ready stays 0; in_valid pulses ignored.
- rst_n low one cycle during ITER at cnt=5 -> next cycle IDLE, out_valid=0, in_ready=1; next transaction result correct.
- Extremes x=-2^31, y=-1 and x=y=2^31-1 -> no overflow, angle ≈ -180°+ε / 45° ±150 LSB, mag within 0.01%.

Source files
------------

// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - arctangent table, angle/gain constants and FSM states for the vectoring CORDIC
package cordic_pkg;

   localparam logic signed [31:0] ANG_90   = 32'sh005A_0000;
   localparam logic        [15:0] GAIN_INV = 16'h9B75;

   // atan(2^-i) in Q16.16 degrees, rounded to nearest
   localparam logic signed [31:0] ATAN [32] = '{
      32'sh002D0000, 32'sh001A90A7, 32'sh000E0947, 32'sh00072001,
      32'sh0003938B, 32'sh0001CA38, 32'sh0000E52A, 32'sh00007297,
      32'sh0000394C, 32'sh00001CA6, 32'sh00000E53, 32'sh00000729,
      32'sh00000395, 32'sh000001CA, 32'sh000000E5, 32'sh00000073,
      32'sh00000039, 32'sh0000001D, 32'sh0000000E, 32'sh00000007,
      32'sh00000004, 32'sh00000002, 32'sh00000001, 32'sh00000000,
      32'sh00000000, 32'sh00000000, 32'sh00000000, 32'sh00000000,
      32'sh00000000, 32'sh00000000, 32'sh00000000, 32'sh00000000
   };

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRE,
      ST_ITER,
      ST_COMP,
      ST_DONE
   } vec_state_t;

endpackage

// File: rtl/cordic_vec_step.sv
// rtl/cordic_vec_step.sv - one combinational vectoring micro-rotation steering y toward zero
module cordic_vec_step #(
   parameter int W  = 34,
   parameter int SW = 5
) (
   input  logic signed [W-1:0]  i_x,
   input  logic signed [W-1:0]  i_y,
   input  logic signed [31:0]   i_z,
   input  logic        [SW-1:0] i_shift,
   input  logic signed [31:0]   i_atan,
   output logic signed [W-1:0]  o_x,
   output logic signed [W-1:0]  o_y,
   output logic signed [31:0]   o_z
);

   logic signed [W-1:0] w_x_sh;
   logic signed [W-1:0] w_y_sh;

   assign w_x_sh = i_x >>> i_shift;
   assign w_y_sh = i_y >>> i_shift;

   always_comb begin
      if (!i_y[W-1]) begin
         o_x = i_x + w_y_sh;
         o_y = i_y - w_x_sh;
         o_z = i_z + i_atan;
      end else begin
         o_x = i_x - w_y_sh;
         o_y = i_y + w_x_sh;
         o_z = i_z - i_atan;
      end
   end

endmodule

// File: rtl/cordic_vectoring_iter.sv
// rtl/cordic_vectoring_iter.sv - iterative vectoring CORDIC (magnitude + atan2) with valid/ready handshakes
// Optional gain correction stage enabled by defining CORDIC_VEC_GAIN_COMP_EN.
module cordic_vectoring_iter
   import cordic_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int ITER  = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [WIDTH-1:0] x_in,
   input  logic signed [WIDTH-1:0] y_in,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic        [WIDTH+1:0] mag_out,
   output logic signed [31:0]      angle_out
);

   localparam int XW = WIDTH + 2;
   localparam int CW = $clog2(WIDTH);

   vec_state_t            r_state;
   vec_state_t            w_state_next;
   logic signed [XW-1:0]  r_x;
   logic signed [XW-1:0]  r_y;
   logic signed [31:0]    r_z;
   logic        [CW-1:0]  r_cnt;
   logic                  r_zero;
   logic        [XW-1:0]  r_mag;
   logic signed [31:0]    r_angle;

   logic signed [XW-1:0]  w_x_step;
   logic signed [XW-1:0]  w_y_step;
   logic signed [31:0]    w_z_step;
   logic                  w_last;

   assign w_last = (r_cnt == CW'(ITER - 1));

   cordic_vec_step #(
      .W  (XW),
      .SW (CW)
   ) u_step (
      .i_x     (r_x),
      .i_y     (r_y),
      .i_z     (r_z),
      .i_shift (r_cnt),
      .i_atan  (ATAN[r_cnt]),
      .o_x     (w_x_step),
      .o_y     (w_y_step),
      .o_z     (w_z_step)
   );

`ifdef CORDIC_VEC_GAIN_COMP_EN
   logic [XW+15:0] w_mag_prod;
   assign w_mag_prod = (XW+16)'($unsigned(r_x)) * (XW+16)'(GAIN_INV);
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) w_state_next = ST_PRE;
         end
         ST_PRE:  w_state_next = ST_ITER;
         ST_ITER: begin
`ifdef CORDIC_VEC_GAIN_COMP_EN
            if (w_last) w_state_next = ST_COMP;
`else
            if (w_last) w_state_next = ST_DONE;
`endif
         end
`ifdef CORDIC_VEC_GAIN_COMP_EN
         ST_COMP: w_state_next = ST_DONE;
`endif
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_x     <= '0;
         r_y     <= '0;
         r_z     <= '0;
         r_cnt   <= '0;
         r_zero  <= 1'b0;
         r_mag   <= '0;
         r_angle <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_x <= {{2{x_in[WIDTH-1]}}, x_in};
                  r_y <= {{2{y_in[WIDTH-1]}}, y_in};
                  r_z <= '0;
               end
            end
            ST_PRE: begin
               // Fold the left half-plane by +/-90 deg; y==0 with x<0 takes the +90 path so it lands on +180.
               r_zero <= (r_x == '0) && (r_y == '0);
               r_cnt  <= '0;
               if (r_x[XW-1] && !r_y[XW-1]) begin
                  r_x <= r_y;
                  r_y <= -r_x;
                  r_z <= ANG_90;
               end else if (r_x[XW-1]) begin
                  r_x <= -r_y;
                  r_y <= r_x;
                  r_z <= -ANG_90;
               end
            end
            ST_ITER: begin
               r_x   <= w_x_step;
               r_y   <= w_y_step;
               r_z   <= w_z_step;
               r_cnt <= r_cnt + CW'(1);
`ifndef CORDIC_VEC_GAIN_COMP_EN
               if (w_last) begin
                  r_mag   <= r_zero ? '0 : $unsigned(w_x_step);
                  r_angle <= r_zero ? '0 : w_z_step;
               end
`endif
            end
`ifdef CORDIC_VEC_GAIN_COMP_EN
            ST_COMP: begin
               r_mag   <= r_zero ? '0 : XW'(w_mag_prod >> 16);
               r_angle <= r_zero ? '0 : r_z;
            end
`endif
            default: begin
            end
         endcase
      end
   end

   assign mag_out   = r_mag;
   assign angle_out = r_angle;

endmodule

// File: tb/tb_cordic_vectoring_iter.sv
// tb/tb_cordic_vectoring_iter.sv - scoreboard bench for cordic_vectoring_iter
module tb_cordic_vectoring_iter;

   localparam int  WIDTH = 32;
   localparam int  ITER  = 16;
   localparam real PI    = 3.14159265358979323846;
`ifdef CORDIC_VEC_GAIN_COMP_EN
   localparam longint LAT = ITER + 2;
`else
   localparam longint LAT = ITER + 1;
`endif

   typedef struct {
      longint mag;
      longint mtol;
      longint ang;
      longint atol;
   } exp_t;

   logic                    clk = 1'b0;
   logic                    rst_n;
   logic                    in_valid;
   logic                    in_ready;
   logic signed [WIDTH-1:0] x_in;
   logic signed [WIDTH-1:0] y_in;
   logic                    out_valid;
   logic                    out_ready;
   logic        [WIDTH+1:0] mag_out;
   logic signed [31:0]      angle_out;

   exp_t   sb[$];
   int     n_cmp = 0;
   int     n_err = 0;
   real    k_gain;
   longint cyc = 0;
   longint acc_cyc = 0;
   logic   ov_q = 1'b0;

   cordic_vectoring_iter #(.WIDTH(WIDTH), .ITER(ITER)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x_in      (x_in),
      .y_in      (y_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .mag_out   (mag_out),
      .angle_out (angle_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input longint got, input longint exp, input longint tol = 0);
      longint diff;
      n_cmp++;
      diff = (got > exp) ? got - exp : exp - got;
      if (diff > tol) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, exp, tol);
      end
   endtask

   // Ideal reference; tolerance widens for small vectors where integer truncation dominates the angle.
   function automatic exp_t model(input longint x, input longint y);
      exp_t e;
      real  r;
      r = $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
      if (x == 0 && y == 0) begin
         e.mag = 0; e.mtol = 0; e.ang = 0; e.atol = 0;
      end else begin
`ifdef CORDIC_VEC_GAIN_COMP_EN
         e.mag = longint'(r);
`else
         e.mag = longint'(k_gain * r);
`endif
         e.mtol = 16 + longint'(k_gain * r * 1.0e-4);
         e.ang  = longint'($atan2(real'(y), real'(x)) * 180.0 / PI * 65536.0);
         e.atol = 150 + longint'(8.0 / (k_gain * r) * 180.0 / PI * 65536.0);
      end
      return e;
   endfunction

   task automatic send(input longint x, input longint y);
      int g = 0;
      while (!in_ready && g < 200) begin
         @(posedge clk); #1;
         g++;
      end
      chk("send_in_ready", longint'(in_ready), 1);
      sb.push_back(model(x, y));
      x_in     = x[WIDTH-1:0];
      y_in     = y[WIDTH-1:0];
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain(input string tag);
      int g = 0;
      while (sb.size() != 0 && g < 400) begin
         @(posedge clk); #1;
         g++;
      end
      chk(tag, longint'(sb.size()), 0);
      @(posedge clk); #1;
   endtask

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst_n && in_valid && in_ready) acc_cyc <= cyc;
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (out_valid && !ov_q) chk("latency", cyc - acc_cyc - 1, LAT);
         if (out_valid && out_ready) begin
            chk("result_expected", longint'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
               chk("mag", longint'(mag_out), sb[0].mag, sb[0].mtol);
               chk("angle", longint'(angle_out), sb[0].ang, sb[0].atol);
               sb.delete(0);
            end
         end
      end
      ov_q <= out_valid;
   end

   initial begin
      int g;
      k_gain = 1.0;
      for (int i = 0; i < ITER; i++) k_gain = k_gain * $sqrt(1.0 + $pow(2.0, -2.0 * i));

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; x_in = '0; y_in = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_out_valid", longint'(out_valid), 0);
      chk("rst_in_ready", longint'(in_ready), 1);
      chk("rst_mag", longint'(mag_out), 0);
      chk("rst_angle", longint'(angle_out), 0);
      @(posedge clk); #1;

      send(30000, 40000);
      drain("drain_main");

      send(1000, 0);
      send(0, 1000);
      send(-1000, 0);
      send(0, -1000);
      send(-1000, -1000);
      drain("drain_quadrants");

      send(0, 0);
      drain("drain_zero");

      send(-64'sd2147483648, -1);
      send(64'sd2147483647, 64'sd2147483647);
      drain("drain_extremes");

      // Hold off the result and poke in_valid; nothing may move or be accepted.
      out_ready = 1'b0;
      send(30000, 40000);
      g = 0;
      while (!out_valid && g < 100) begin
         @(posedge clk); #1;
         g++;
      end
      chk("stall_reach_done", longint'(out_valid), 1);
      for (int i = 0; i < 10; i++) begin
         in_valid = (i == 3 || i == 6);
         x_in = 5; y_in = 7;
         @(negedge clk);
         chk("stall_out_valid", longint'(out_valid), 1);
         chk("stall_in_ready", longint'(in_ready), 0);
         if (sb.size() != 0) begin
            chk("stall_mag", longint'(mag_out), sb[0].mag, sb[0].mtol);
            chk("stall_angle", longint'(angle_out), sb[0].ang, sb[0].atol);
         end
         @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      drain("drain_stall");
      chk("post_stall_in_ready", longint'(in_ready), 1);

      // Abort while the counter sits at 5.
      send(12345, -6789);
      repeat (6) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      chk("abort_out_valid", longint'(out_valid), 0);
      chk("abort_in_ready", longint'(in_ready), 1);
      sb.delete(sb.size() - 1);
      repeat (25) @(posedge clk);
      #1;
      chk("abort_no_result", longint'(out_valid), 0);

      send(-20000, 15000);
      drain("drain_after_abort");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
